audio_loop_buf: RTL and testbench
=================================

Name: audio_loop_buf

Overview:
- Sits between the codec control block's receive and send paths, in the system clock domain.
- Receives stereo samples via the adc_data/rx_done pair and applies per-sample volume scaling with saturation and mute.
- Buffers the scaled samples in a small FIFO, then releases them on dac_data, one word per tx_done event.
- Provides loopback/monitor playback with underflow and overflow reporting.

Parameters:
- AW, 4, FIFO address width; depth = 2**AW words of 32 bits.
- PRIME, 8, fill level required before playback (re)starts; legal range 1..2**AW.

Ports:
- clk  input  1  system clock; must be at least 4x aud_bclk.
- rst_n  input  1  asynchronous active-low reset.
- adc_data  input  32  received frame, {left[31:16], right[15:0]}, signed two's complement; stable for at least 3 clk after rx_done rises.
- rx_done  input  1  receive-complete pulse from the aud_bclk domain; asynchronous to clk.
- tx_done  input  1  send-complete pulse from the aud_bclk domain; asynchronous to clk.
- dac_data  output  32  frame to transmit, {left, right}.
- vol  input  8  unsigned gain in Q1.7 format (128 = unity, 255 ~ 1.99x).
- mute  input  1  forces written samples to 0.
- clr_flags  input  1  synchronous clear of the sticky flags.
- level  output  AW+1  current FIFO occupancy.
- playing  output  1  high while primed and draining.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, rst_n low) clears all of the following:
  - dac_data = 0, level = 0, playing = 0, ovf = 0, udf = 0.
  - FIFO pointers, synchronisers and pipeline valid bits.
- Event synchronisation:
  - rx_done and tx_done each pass through a 2-FF synchroniser followed by a rising-edge detect.
  - The edge detect produces rx_evt / tx_evt, each a 1-clk pulse.
  - A pulse held high for many clk yields exactly one event.
- Write pipeline:
  - Stage 1, on rx_evt: capture adc_data halves and vol/mute into registers.
  - Stage 2: compute p = sample * {1'b0, vol} (signed 16 x signed 9 -> 25 bit), then arithmetic shift right 7.
  - Saturate the result to [-32768, 32767] per channel. If mute, the result is 0.
  - Stage 3: write {L, R} into the FIFO.
  - rx_evt to FIFO write = 2 clk; level increments on the write cycle.
- Overflow: a write while level == 2**AW drops the new word, leaves the FIFO unchanged and sets ovf.
- Read state machine, states PRIMING and PLAY:
  - PRIMING: on tx_evt, dac_data <= 0 and udf is not set. Move to PLAY when level >= PRIME; the check is evaluated every clk.
  - PLAY: on tx_evt with level > 0, pop the head word; dac_data updates 1 clk after tx_evt.
  - PLAY with tx_evt and level == 0: dac_data <= 0, set udf, return to PRIMING.
  - playing = 1 exactly in PLAY.
- Simultaneous write and pop in the same clk: both happen and level is unchanged. When full, a simultaneous write and pop is not an overflow.
- Pointers wrap modulo 2**AW. level is the difference of (AW+1)-bit pointers.
- dac_data holds its value between tx_evt pulses.
- clr_flags clears ovf/udf. If a set event occurs in the same clk, set wins.
- Changing vol/mute affects only samples whose rx_evt occurs after the change.
- Reset asserted mid-operation: immediate return to the reset values above; in-flight pipeline data is discarded.

Test Plan:
- Prime and play: AW=4, PRIME=8, vol=128. Send 8 rx pulses with adc_data = {16'h0100+i, 16'hFF00-i}, then tx pulses.
  - During the first 8 rx: dac_data stays 0 and playing=0.
  - After level reaches 8: playing=1, and the tx pulses return the words in order, unchanged.
- Gain and saturation:
  - vol=255, left=16'h7000 -> 16'h7FFF; right=16'h9000 -> 16'h8000.
  - vol=64, left=16'h1000 -> 16'h0800; right=16'hF000 -> 16'hF800.
  - mute=1 -> 32'h0.
- Overflow: 17 rx pulses with no tx.
  - level=16, ovf=1, and the 17th word is absent when the FIFO is drained.
  - clr_flags -> ovf=0.
- Underflow: drain to empty in PLAY, then one more tx.
  - dac_data=0, udf=1, playing=0.
  - Refill to 8 -> playing=1.
- Simultaneous events and pulse width: rx and tx edges aligned at level=16.
  - level stays 16 and ovf stays 0.
  - An rx_done held high for 10 clk produces a single write.
- Async reset mid-stream: rst_n low for 1 clk at level=5 while playing.
  - All outputs are 0 immediately.
  - Subsequent tx pulses return 0 until re-primed.

Source files
------------

// File: rtl/audio_loop_buf.sv
// Audio loopback buffer: synchronises codec rx/tx pulses, scales received stereo
// samples by vol with saturation and mute, and replays them through a primed FIFO.
module audio_loop_buf #(
  parameter int AW    = 4,
  parameter int PRIME = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   adc_data,
  input  logic          rx_done,
  input  logic          tx_done,
  output logic [31:0]   dac_data,
  input  logic [7:0]    vol,
  input  logic          mute,
  input  logic          clr_flags,
  output logic [AW:0]   level,
  output logic          playing,
  output logic          ovf,
  output logic          udf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME);

  typedef enum logic {PRIMING, PLAY} state_t;

  state_t       state;
  logic [2:0]   rx_sync;
  logic [2:0]   tx_sync;
  logic         rx_evt;
  logic         tx_evt;

  logic         s1_valid;
  logic [15:0]  s1_left;
  logic [15:0]  s1_right;
  logic [7:0]   s1_vol;
  logic         s1_mute;
  logic [31:0]  wr_word;

  logic [31:0]  mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  logic         ovf_set;

  // Two flops of synchronisation, the third flop only remembers the previous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '0;
      tx_sync <= '0;
    end else begin
      rx_sync <= {rx_sync[1:0], rx_done};
      tx_sync <= {tx_sync[1:0], tx_done};
    end
  end

  assign rx_evt = rx_sync[1] & ~rx_sync[2];
  assign tx_evt = tx_sync[1] & ~tx_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_left  <= '0;
      s1_right <= '0;
      s1_vol   <= '0;
      s1_mute  <= 1'b0;
    end else begin
      s1_valid <= rx_evt;
      if (rx_evt) begin
        s1_left  <= adc_data[31:16];
        s1_right <= adc_data[15:0];
        s1_vol   <= vol;
        s1_mute  <= mute;
      end
    end
  end

  // Q1.7 gain: the top 18 bits of the 25-bit product are the value shifted right by 7
  function automatic logic [15:0] apply_gain(input logic [15:0] sample, input logic [7:0] gain);
    logic signed [24:0] prod;
    logic signed [17:0] shifted;
    prod    = $signed(sample) * $signed({1'b0, gain});
    shifted = prod[24:7];
    if (shifted[17:15] == 3'b000 || shifted[17:15] == 3'b111)
      apply_gain = shifted[15:0];
    else if (shifted[17])
      apply_gain = 16'h8000;
    else
      apply_gain = 16'h7FFF;
  endfunction

  always_comb begin
    wr_word = '0;
    if (!s1_mute)
      wr_word = {apply_gain(s1_left, s1_vol), apply_gain(s1_right, s1_vol)};
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign pop     = tx_evt && (state == PLAY) && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted
  assign push    = s1_valid && (!full || pop);
  assign ovf_set = s1_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_flags)
        ovf <= 1'b0;
    end
  end

  // Playback FSM; a later udf set overrides the clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRIMING;
      dac_data <= '0;
      playing  <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (clr_flags)
        udf <= 1'b0;
      case (state)
        PRIMING: begin
          if (tx_evt)
            dac_data <= '0;
          if (level >= PRIME_L) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (tx_evt) begin
            if (!empty) begin
              dac_data <= mem[rd_ptr[AW-1:0]];
            end else begin
              dac_data <= '0;
              udf      <= 1'b1;
              state    <= PRIMING;
              playing  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= PRIMING;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_loop_buf.sv
// Self-checking bench for audio_loop_buf: directed scenarios plus random rx/tx
// traffic compared against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_audio_loop_buf;

  localparam int AW    = 4;
  localparam int PRIME = 8;
  localparam int DEPTH = 1 << AW;

  localparam int OP_RX      = 0;
  localparam int OP_TX      = 1;
  localparam int OP_ALIGNED = 2;
  localparam int OP_OFFSET  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   adc_data = '0;
  logic          rx_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [31:0]   dac_data;
  logic [7:0]    vol = 8'd128;
  logic          mute = 1'b0;
  logic          clr_flags = 1'b0;
  logic [AW:0]   level;
  logic          playing;
  logic          ovf;
  logic          udf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_dac;
  bit          m_play;
  bit          m_ovf;
  bit          m_udf;

  audio_loop_buf #(.AW(AW), .PRIME(PRIME)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .rx_done   (rx_done),
    .tx_done   (tx_done),
    .dac_data  (dac_data),
    .vol       (vol),
    .mute      (mute),
    .clr_flags (clr_flags),
    .level     (level),
    .playing   (playing),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference gain: scale by vol/128 rounding toward minus infinity, then clamp
  function automatic logic [15:0] ref_gain(input logic [15:0] x, input int g);
    int p;
    p = int'($signed(x)) * g;
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] d, input int g, input bit m);
    if (m) return 32'h0;
    return {ref_gain(d[31:16], g), ref_gain(d[15:0], g)};
  endfunction

  task automatic model_rx(input logic [31:0] d);
    if (m_q.size() == DEPTH)
      m_ovf = 1;
    else
      m_q.push_back(ref_word(d, int'(vol), mute));
    if (!m_play && m_q.size() >= PRIME)
      m_play = 1;
  endtask

  task automatic model_tx();
    if (!m_play)
      m_dac = 32'h0;
    else if (m_q.size() > 0)
      m_dac = m_q.pop_front();
    else begin
      m_dac  = 32'h0;
      m_udf  = 1;
      m_play = 0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dac  = 32'h0;
    m_play = 0;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_dac"},   dac_data,      m_dac);
    checkOutput({tag, "_level"}, 32'(level),    32'(m_q.size()));
    checkOutput({tag, "_play"},  32'(playing),  32'(m_play));
    checkOutput({tag, "_ovf"},   32'(ovf),      32'(m_ovf));
    checkOutput({tag, "_udf"},   32'(udf),      32'(m_udf));
  endtask

  task automatic applyStimulus(input int op, input logic [31:0] d, input int hold);
    case (op)
      OP_RX: begin
        adc_data = d;
        rx_done  = 1'b1;
        tick(hold);
        rx_done  = 1'b0;
        tick(4);
        model_rx(d);
      end
      OP_TX: begin
        tx_done = 1'b1;
        tick(hold);
        tx_done = 1'b0;
        tick(3);
        model_tx();
      end
      OP_ALIGNED: begin
        adc_data = d;
        rx_done  = 1'b1;
        tx_done  = 1'b1;
        tick(hold);
        rx_done  = 1'b0;
        tx_done  = 1'b0;
        tick(4);
        model_tx();
        model_rx(d);
      end
      default: begin
        adc_data = d;
        rx_done  = 1'b1;
        tick(1);
        tx_done  = 1'b1;
        tick(hold);
        rx_done  = 1'b0;
        tx_done  = 1'b0;
        tick(4);
        model_tx();
        model_rx(d);
      end
    endcase
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_reset();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    m_ovf = 0;
    m_udf = 0;
  endtask

  initial begin
    int op;
    logic [31:0] d;
    $display("[TB] start");
    model_reset();
    do_reset();
    checkAll("reset");

    // Prime, play in order, underflow, re-prime
    for (int i = 0; i < 8; i++) begin
      d = {16'h0100 + 16'(i), 16'hFF00 - 16'(i)};
      applyStimulus(OP_RX, d, 3);
      checkAll("prime_rx");
    end
    checkOutput("primed_play", 32'(playing), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_TX, 32'h0, 3);
      checkOutput("play_word", dac_data, {16'h0100 + 16'(i), 16'hFF00 - 16'(i)});
      checkAll("play_tx");
    end
    applyStimulus(OP_TX, 32'h0, 3);
    checkAll("underflow");
    checkOutput("udf_set", 32'(udf), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_RX, $urandom, 3);
      checkAll("refill");
    end

    // Gain, saturation, mute
    do_reset();
    vol = 8'd255;
    applyStimulus(OP_RX, {16'h7000, 16'h9000}, 3);
    vol = 8'd64;
    applyStimulus(OP_RX, {16'h1000, 16'hF000}, 3);
    mute = 1'b1;
    applyStimulus(OP_RX, 32'h1234_5678, 3);
    mute = 1'b0;
    vol  = 8'd128;
    for (int i = 0; i < 5; i++) applyStimulus(OP_RX, $urandom, 3);
    applyStimulus(OP_TX, 32'h0, 3);
    checkOutput("gain255", dac_data, 32'h7FFF_8000);
    applyStimulus(OP_TX, 32'h0, 3);
    checkOutput("gain64", dac_data, 32'h0800_F800);
    applyStimulus(OP_TX, 32'h0, 3);
    checkOutput("mute", dac_data, 32'h0);
    checkAll("gain");

    // Overflow: the 17th word is dropped
    do_reset();
    for (int i = 0; i < 17; i++) applyStimulus(OP_RX, $urandom, 3);
    checkAll("ovf");
    checkOutput("ovf_level", 32'(level), 32'd16);
    pulse_clr();
    checkAll("ovf_clr");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(OP_TX, 32'h0, 3);
      checkAll("ovf_drain");
    end

    // Simultaneous events at full, and a long rx pulse
    do_reset();
    for (int i = 0; i < 16; i++) applyStimulus(OP_RX, $urandom, 3);
    applyStimulus(OP_ALIGNED, $urandom, 3);
    checkAll("aligned");
    applyStimulus(OP_OFFSET, $urandom, 3);
    checkAll("same_clk");
    checkOutput("same_clk_ovf", 32'(ovf), 32'h0);
    applyStimulus(OP_TX, 32'h0, 3);
    applyStimulus(OP_RX, $urandom, 10);
    checkAll("long_rx");

    // Asynchronous reset at level 5 while playing
    do_reset();
    for (int i = 0; i < 17; i++) applyStimulus(OP_RX, $urandom, 3);
    for (int i = 0; i < 11; i++) applyStimulus(OP_TX, 32'h0, 3);
    checkAll("pre_rst");
    #2;
    rst_n = 1'b0;
    #2;
    model_reset();
    checkAll("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_TX, 32'h0, 3);
      checkAll("post_rst_tx");
    end
    for (int i = 0; i < 8; i++) applyStimulus(OP_RX, $urandom, 3);
    checkAll("reprime");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      vol  = 8'($urandom);
      mute = ($urandom_range(0, 9) == 0);
      op   = $urandom_range(0, 19);
      d    = $urandom;
      if (op < 9)       applyStimulus(OP_RX, d, $urandom_range(3, 6));
      else if (op < 18) applyStimulus(OP_TX, 32'h0, $urandom_range(3, 6));
      else if (op < 19) applyStimulus(OP_OFFSET, d, 3);
      else              pulse_clr();
      checkAll("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
